// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
//   Definitions shared by both ends of the 7-segment digit interface (segment
//   driver and seg7_capture), so that both use one glyph table.
//   - SEG_W        : number of segment lines (7)
//   - seg_pat_t    : segment pattern, index 0 = g ... index 6 = a, so a
//                    literal is written left to right as g f e d c b a
//   - GLYPH_TABLE  : active-high segment pattern for each hex nibble 0..F
//   - SEG_BLANK    : all segments off
//   - cap_state_t  : capture FSM states
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam int SEG_W    = 7;
  localparam int NIBBLE_W = 4;
  localparam int N_GLYPHS = 16;

  typedef logic [0:SEG_W-1] seg_pat_t;

  localparam seg_pat_t SEG_BLANK = 7'b0000000;

  // Entry i is the pattern that displays hex digit i.
  localparam seg_pat_t GLYPH_TABLE [N_GLYPHS] = '{
    7'b0111111,  // 0
    7'b0000110,  // 1
    7'b1011011,  // 2
    7'b1001111,  // 3
    7'b1100110,  // 4
    7'b1101101,  // 5
    7'b1111101,  // 6
    7'b0000111,  // 7
    7'b1111111,  // 8
    7'b1101111,  // 9
    7'b1110111,  // A
    7'b1111100,  // b
    7'b0111001,  // C
    7'b1011110,  // d
    7'b1111001,  // E
    7'b1110001   // F
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } cap_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// -----------------------------------------------------------------------------
// seg7_pattern_decode
//   Combinational reverse lookup of a normalized (active-high) segment pattern
//   into its hex nibble.
//   Ports:
//     pat    in   seg_pat_t  normalized segment pattern (index 0 = g)
//     hit    out  1          pattern matches one of the 16 glyphs
//     nibble out  4          nibble of the matching glyph, 0 when no hit
// -----------------------------------------------------------------------------
import seg7_pkg::*;

module seg7_pattern_decode (
  input  seg_pat_t                pat,
  output logic                    hit,
  output logic [NIBBLE_W-1:0]     nibble
);

  // Compare against every glyph; the table entries are unique, so at most one matches.
  always_comb begin
    hit    = 1'b0;
    nibble = {NIBBLE_W{1'b0}};
    for (int i = 0; i < N_GLYPHS; i++) begin
      if (pat == GLYPH_TABLE[i]) begin
        hit    = 1'b1;
        nibble = NIBBLE_W'(i);
      end else begin
        hit    = hit;
        nibble = nibble;
      end
    end
  end

endmodule

// File: rtl/seg7_capture.sv
// -----------------------------------------------------------------------------
// seg7_capture
//   Receive side of a multiplexed 7-segment bus. Synchronizes the segment
//   lines, the one-hot digit select and the polarity strap, waits until the
//   normalized {pattern, select} pair has been stable for STABLE_CYCLES
//   samples, then decodes the pattern once and stores the nibble for the
//   selected digit.
//
//   Optional feature (compile-time macro SEG7_BLANK_DETECT_EN):
//     defined     : an all-off pattern clears valid_o for that digit and pulses
//                   upd_o (digit nibble kept, no err_o)
//     not defined : an all-off pattern is a glyph miss and pulses err_o
//
//   Ports:
//     clk_i       in   1             system clock
//     rst_ni      in   1             asynchronous active-low reset
//     seg_i       in   [0:6]         segment lines, index 0 = g ... 6 = a
//     sel_i       in   N_DIGITS      digit select, one-hot, active high
//     polarity_i  in   1             1: segments active high, 0: active low
//     digits_o    out  4*N_DIGITS    decoded nibbles, digit k at [4k+3:4k]
//     valid_o     out  N_DIGITS      digit k holds a decoded value (sticky)
//     upd_o       out  1             one-cycle pulse: a digit entry was written
//     upd_idx_o   out  IDX_W         index of written digit while upd_o = 1
//     err_o       out  1             one-cycle pulse: stable pattern is no glyph
// -----------------------------------------------------------------------------
import seg7_pkg::*;

module seg7_capture #(
  parameter  int N_DIGITS      = 4,
  parameter  int STABLE_CYCLES = 4,
  localparam int IDX_W         = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  seg_pat_t                seg_i,
  input  logic [N_DIGITS-1:0]     sel_i,
  input  logic                    polarity_i,
  output logic [4*N_DIGITS-1:0]   digits_o,
  output logic [N_DIGITS-1:0]     valid_o,
  output logic                    upd_o,
  output logic [IDX_W-1:0]        upd_idx_o,
  output logic                    err_o
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO      = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W:0]   STABLE_TARGET = (CNT_W + 1)'(STABLE_CYCLES);

`ifdef SEG7_BLANK_DETECT_EN
  localparam bit BLANK_DETECT = 1'b1;
`else
  localparam bit BLANK_DETECT = 1'b0;
`endif

  // Two-flop synchronizer stages.
  seg_pat_t              seg_meta_r;
  seg_pat_t              seg_sync_r;
  logic [N_DIGITS-1:0]   sel_meta_r;
  logic [N_DIGITS-1:0]   sel_sync_r;
  logic                  pol_meta_r;
  logic                  pol_sync_r;

  // Previous-cycle copy of the normalized sample, used both for change
  // detection and as the value decoded in the CAPTURE cycle.
  seg_pat_t              stable_pat_r;
  logic [N_DIGITS-1:0]   stable_sel_r;

  cap_state_t            state_r;
  logic [CNT_W-1:0]      cnt_r;

  seg_pat_t              pat_s;
  logic                  one_hot_s;
  logic                  change_s;
  logic                  blank_s;
  logic [CNT_W:0]        cnt_inc_s;
  logic [IDX_W-1:0]      cap_idx_s;
  logic                  dec_hit_s;
  logic [NIBBLE_W-1:0]   dec_nibble_s;

  // Bring the asynchronous pin inputs into the clock domain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seg_meta_r <= {SEG_W{1'b0}};
      seg_sync_r <= {SEG_W{1'b0}};
      sel_meta_r <= {N_DIGITS{1'b0}};
      sel_sync_r <= {N_DIGITS{1'b0}};
      pol_meta_r <= 1'b0;
      pol_sync_r <= 1'b0;
    end else begin
      seg_meta_r <= seg_i;
      seg_sync_r <= seg_meta_r;
      sel_meta_r <= sel_i;
      sel_sync_r <= sel_meta_r;
      pol_meta_r <= polarity_i;
      pol_sync_r <= pol_meta_r;
    end
  end

  // Normalize to active-high so decode and change detection ignore bus sense.
  always_comb begin
    if (pol_sync_r) begin
      pat_s = seg_sync_r;
    end else begin
      pat_s = ~seg_sync_r;
    end
  end

  // Sample classification: select validity, change since last cycle, blank.
  always_comb begin
    one_hot_s = (sel_sync_r != {N_DIGITS{1'b0}}) &&
                ((sel_sync_r & (sel_sync_r - N_DIGITS'(1))) == {N_DIGITS{1'b0}});
    change_s  = (pat_s != stable_pat_r) || (sel_sync_r != stable_sel_r);
    blank_s   = (stable_pat_r == SEG_BLANK);
    cnt_inc_s = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};
  end

  // Binary index of the digit being captured (stable_sel_r is one-hot there).
  always_comb begin
    cap_idx_s = {IDX_W{1'b0}};
    for (int k = 0; k < N_DIGITS; k++) begin
      if (stable_sel_r[k]) begin
        cap_idx_s = IDX_W'(k);
      end else begin
        cap_idx_s = cap_idx_s;
      end
    end
  end

  seg7_pattern_decode u_decode (
    .pat    (stable_pat_r),
    .hit    (dec_hit_s),
    .nibble (dec_nibble_s)
  );

  // Stability FSM with its run counter and the registered digit/valid/pulse outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_ZERO;
      stable_pat_r <= {SEG_W{1'b0}};
      stable_sel_r <= {N_DIGITS{1'b0}};
      digits_o     <= {(4 * N_DIGITS){1'b0}};
      valid_o      <= {N_DIGITS{1'b0}};
      upd_o        <= 1'b0;
      upd_idx_o    <= {IDX_W{1'b0}};
      err_o        <= 1'b0;
    end else begin
      upd_o        <= 1'b0;
      err_o        <= 1'b0;
      stable_pat_r <= pat_s;
      stable_sel_r <= sel_sync_r;

      case (state_r)
        IDLE: begin
          if (one_hot_s) begin
            state_r <= SETTLE;
            cnt_r   <= CNT_ONE;
          end else begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
          end
        end

        SETTLE: begin
          if (!one_hot_s) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
          end else if (change_s) begin
            cnt_r   <= CNT_ONE;
          end else if (cnt_inc_s >= STABLE_TARGET) begin
            state_r <= CAPTURE;
            cnt_r   <= cnt_inc_s[CNT_W-1:0];
          end else begin
            cnt_r   <= cnt_inc_s[CNT_W-1:0];
          end
        end

        CAPTURE: begin
          // Decode the value that was stable, not the current sample.
          if (BLANK_DETECT && blank_s) begin
            upd_o     <= 1'b1;
            upd_idx_o <= cap_idx_s;
            for (int k = 0; k < N_DIGITS; k++) begin
              if (stable_sel_r[k]) valid_o[k] <= 1'b0;
            end
          end else if (dec_hit_s) begin
            upd_o     <= 1'b1;
            upd_idx_o <= cap_idx_s;
            for (int k = 0; k < N_DIGITS; k++) begin
              if (stable_sel_r[k]) begin
                digits_o[4*k +: 4] <= dec_nibble_s;
                valid_o[k]         <= 1'b1;
              end
            end
          end else begin
            err_o <= 1'b1;
          end

          // A change arriving in this very cycle already starts the next run.
          if (change_s) begin
            state_r <= SETTLE;
            cnt_r   <= CNT_ONE;
          end else begin
            state_r <= HOLD;
          end
        end

        HOLD: begin
          if (!one_hot_s) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
          end else if (change_s) begin
            state_r <= SETTLE;
            cnt_r   <= CNT_ONE;
          end else begin
            state_r <= HOLD;
          end
        end

        default: begin
          state_r <= IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// -----------------------------------------------------------------------------
// tb_seg7_capture
//   Directed and randomized stimulus for seg7_capture (N_DIGITS=4,
//   STABLE_CYCLES=4). The reference model tracks run lengths of the
//   normalized {pattern, select} pair at pin level: the STABLE_CYCLES-th
//   identical one-hot sample of a run produces one decode event, visible on
//   the outputs four clocks after that sample was driven.
// -----------------------------------------------------------------------------
import seg7_pkg::*;

module tb_seg7_capture;

  localparam int ND   = 4;
  localparam int ST   = 4;
  localparam int MAXC = 4096;

`ifdef SEG7_BLANK_DETECT_EN
  localparam bit TB_BLANK = 1'b1;
`else
  localparam bit TB_BLANK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_ni = 1'b1;
  logic [0:6]      seg = 7'b0000000;
  logic [ND-1:0]   sel = 4'b0000;
  logic            pol = 1'b0;
  logic [4*ND-1:0] digits_o;
  logic [ND-1:0]   valid_o;
  logic            upd_o;
  logic [1:0]      upd_idx_o;
  logic            err_o;

  seg7_capture #(.N_DIGITS(ND), .STABLE_CYCLES(ST)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .seg_i      (seg),
    .sel_i      (sel),
    .polarity_i (pol),
    .digits_o   (digits_o),
    .valid_o    (valid_o),
    .upd_o      (upd_o),
    .upd_idx_o  (upd_idx_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int upd_seen = 0;
  int err_seen = 0;

  // Reference glyphs written straight from the digit shapes (g..a order).
  logic [0:6] glyph [16];

  // Model state.
  logic [3:0]  m_dig [ND];
  logic [ND-1:0] m_val;
  logic [10:0] last_key;
  bit          last_ok;
  int          run_len;
  int          ev_kind [MAXC];  // 0 none, 1 write, 2 blank clear, 3 error
  int          ev_idx  [MAXC];
  int          ev_nib  [MAXC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int glyph_lookup(input logic [0:6] p);
    int r;
    r = -1;
    for (int i = 0; i < 16; i++) if (glyph[i] == p) r = i;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ND; i++) m_dig[i] = 4'h0;
    m_val   = 4'b0000;
    last_ok = 1'b0;
    run_len = 0;
    for (int i = 0; i < MAXC; i++) ev_kind[i] = 0;
  endtask

  // One clock: drive pins (pattern given active-high), update model, check outputs.
  task automatic step(input logic [0:6] pat, input logic [ND-1:0] s, input logic p);
    logic [10:0] key;
    int g, k, idx;
    logic e_upd, e_err;
    @(posedge clk);
    cyc++;
    #1;
    pol = p;
    sel = s;
    seg = p ? pat : ~pat;
    key = {pat, s};
    if (last_ok && key == last_key) run_len++;
    else run_len = 1;
    last_key = key;
    last_ok  = 1'b1;
    if ($countones(s) == 1 && run_len == ST && cyc + 4 < MAXC) begin
      idx = 0;
      for (int i = 0; i < ND; i++) if (s[i]) idx = i;
      g = glyph_lookup(pat);
      ev_idx[cyc + 4] = idx;
      if (g >= 0) begin
        ev_kind[cyc + 4] = 1;
        ev_nib[cyc + 4]  = g;
      end else if (TB_BLANK && pat == 7'b0000000) begin
        ev_kind[cyc + 4] = 2;
      end else begin
        ev_kind[cyc + 4] = 3;
      end
    end
    @(negedge clk);
    k     = ev_kind[cyc];
    e_upd = (k == 1) || (k == 2);
    e_err = (k == 3);
    if (k == 1) begin
      m_dig[ev_idx[cyc]] = 4'(ev_nib[cyc]);
      m_val[ev_idx[cyc]] = 1'b1;
    end
    if (k == 2) m_val[ev_idx[cyc]] = 1'b0;
    chk("upd", upd_o, e_upd);
    chk("err", err_o, e_err);
    if (e_upd) chk("upd_idx", upd_idx_o, ev_idx[cyc]);
    chk("digits", digits_o, {m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
    chk("valid", valid_o, m_val);
    if (upd_o === 1'b1) upd_seen++;
    if (err_o === 1'b1) err_seen++;
  endtask

  task automatic hold(input logic [0:6] pat, input logic [ND-1:0] s, input logic p, input int n);
    for (int i = 0; i < n; i++) step(pat, s, p);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_digits"}, digits_o, 32'h0);
    chk({tag, "_valid"}, valid_o, 32'h0);
    chk({tag, "_upd"}, upd_o, 32'h0);
    chk({tag, "_err"}, err_o, 32'h0);
    chk({tag, "_idx"}, upd_idx_o, 32'h0);
  endtask

  task automatic do_reset();
    #1 rst_ni = 1'b0;
    sel = 4'b0000;
    seg = 7'b0000000;
    pol = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_held");
    rst_ni = 1'b1;
    hold(7'b0000000, 4'b0000, 1'b0, 3);
  endtask

  logic [0:6]    r_pat;
  logic [ND-1:0] r_sel;
  logic          r_pol;
  int            r_kind;
  int            r_len;

  initial begin
    glyph = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
              7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
              7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
              7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
    model_clear();
    do_reset();

    // 1: '0' on digit 0, active-high bus; exactly one update while held.
    upd_seen = 0;
    hold(glyph[0], 4'b0001, 1'b1, 14);
    chk("t1_upd_count", upd_seen, 1);
    chk("t1_digit0", digits_o[3:0], 4'h0);
    chk("t1_valid", valid_o, 4'b0001);

    // 2: '3' on digit 2 with inverted bus.
    hold(glyph[3], 4'b0100, 1'b0, 10);
    chk("t2_digit2", digits_o[11:8], 4'h3);
    chk("t2_valid2", valid_o[2], 1'b1);

    // 3: '5' too short to settle, then '6' held.
    upd_seen = 0;
    hold(glyph[5], 4'b0010, 1'b1, 3);
    hold(glyph[6], 4'b0010, 1'b1, 10);
    chk("t3_upd_count", upd_seen, 1);
    chk("t3_digit1", digits_o[7:4], 4'h6);

    // 4: pattern that is no glyph.
    upd_seen = 0;
    err_seen = 0;
    hold(7'b0101010, 4'b1000, 1'b1, 10);
    chk("t4_err_count", err_seen, 1);
    chk("t4_upd_count", upd_seen, 0);
    chk("t4_valid3", valid_o[3], 1'b0);
    chk("t4_digit3", digits_o[15:12], 4'h0);

    // 5: select not one-hot.
    upd_seen = 0;
    err_seen = 0;
    hold(glyph[1], 4'b0011, 1'b1, 10);
    hold(glyph[1], 4'b0000, 1'b1, 10);
    chk("t5_pulses", upd_seen + err_seen, 0);

    // Blank pattern on digit 0 (which holds '0').
    upd_seen = 0;
    err_seen = 0;
    hold(7'b0000000, 4'b0001, 1'b1, 10);
    chk("blank_valid0", valid_o[0], TB_BLANK ? 1'b0 : 1'b1);
    chk("blank_upd", upd_seen, TB_BLANK ? 1 : 0);
    chk("blank_err", err_seen, TB_BLANK ? 0 : 1);
    chk("blank_digit0", digits_o[3:0], 4'h0);

    // 6: load digit 1, then reset while the next pattern is settling.
    hold(glyph[9], 4'b0010, 1'b1, 10);
    chk("t6_loaded", digits_o[7:4], 4'h9);
    hold(glyph[2], 4'b0010, 1'b1, 4);
    do_reset();

    // Randomized runs: glyphs, garbage, blanks, bad selects, polarity flips.
    for (int t = 0; t < 120; t++) begin
      r_kind = $urandom_range(0, 9);
      r_sel  = 4'b0001 << $urandom_range(0, 3);
      r_pol  = 1'($urandom_range(0, 1));
      r_pat  = glyph[$urandom_range(0, 15)];
      if (r_kind == 6) r_pat = 7'($urandom);
      if (r_kind == 7) r_pat = 7'b0000000;
      if (r_kind == 8) r_sel = 4'($urandom);
      r_len = $urandom_range(1, 8);
      for (int j = 0; j < r_len; j++) begin
        // Same pattern with the opposite bus sense must not count as a change.
        if ($urandom_range(0, 4) == 0) r_pol = ~r_pol;
        step(r_pat, r_sel, r_pol);
      end
    end
    hold(7'b0000000, 4'b0000, 1'b1, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
